// File: rtl/fft_bus_master.sv
// fft_bus_master: streams four complex samples into the radix-4 butterfly
// over the peripheral bus, waits, then reads back and streams the results.
module fft_bus_master #(
  parameter logic [13:0] BASE_ADDR   = 14'h88,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        mclk,
  input  logic        puc_rst_n,
  input  logic        flush,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_re,
  input  logic [15:0] s_im,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_re,
  output logic [15:0] m_im,
  output logic [1:0]  m_idx,
  output logic        m_last,
  output logic [13:0] per_addr,
  output logic [15:0] per_din,
  output logic        per_en,
  output logic [1:0]  per_we,
  input  logic [15:0] per_dout,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_WAIT,
    S_READ,
    S_OUT
  } state_t;

  localparam logic [7:0] WLAST = 8'(WAIT_CYCLES - 1);

  state_t      state, state_n;
  logic [1:0]  k, k_n;
  logic [1:0]  phase, phase_n;
  logic [7:0]  wcnt, wcnt_n;
  logic [15:0] im_q, im_q_n;
  logic [13:0] addr_n;
  logic [15:0] din_n;
  logic        en_n;
  logic [1:0]  we_n;
  logic        mv_n;
  logic [15:0] mre_n, mim_n;
  logic [1:0]  midx_n;
  logic        mlast_n;
  logic [13:0] a_even, a_odd;

  assign a_even  = BASE_ADDR + {11'd0, k, 1'b0};
  assign a_odd   = a_even + 14'd1;
  assign s_ready = (state == S_LOAD) && (phase == 2'd0);
  assign busy    = !((state == S_LOAD) && (k == 2'd0)
                     && (phase == 2'd0));

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state    <= S_LOAD;
      k        <= 2'd0;
      phase    <= 2'd0;
      wcnt     <= 8'd0;
      im_q     <= 16'd0;
      per_addr <= 14'd0;
      per_din  <= 16'd0;
      per_en   <= 1'b0;
      per_we   <= 2'b00;
      m_valid  <= 1'b0;
      m_re     <= 16'd0;
      m_im     <= 16'd0;
      m_idx    <= 2'd0;
      m_last   <= 1'b0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      phase    <= phase_n;
      wcnt     <= wcnt_n;
      im_q     <= im_q_n;
      per_addr <= addr_n;
      per_din  <= din_n;
      per_en   <= en_n;
      per_we   <= we_n;
      m_valid  <= mv_n;
      m_re     <= mre_n;
      m_im     <= mim_n;
      m_idx    <= midx_n;
      m_last   <= mlast_n;
    end
  end

  always_comb begin
    state_n = state;
    k_n     = k;
    phase_n = phase;
    wcnt_n  = wcnt;
    im_q_n  = im_q;
    addr_n  = per_addr;
    din_n   = per_din;
    en_n    = 1'b0;
    we_n    = 2'b00;
    mv_n    = m_valid;
    mre_n   = m_re;
    mim_n   = m_im;
    midx_n  = m_idx;
    mlast_n = m_last;

    unique case (state)
      S_LOAD: begin
        unique case (phase)
          2'd0: begin
            if (s_valid) begin
              im_q_n  = s_im;
              en_n    = 1'b1;
              we_n    = 2'b11;
              addr_n  = a_even;
              din_n   = s_re;
              phase_n = 2'd1;
            end
          end
          2'd1: begin
            en_n    = 1'b1;
            we_n    = 2'b11;
            addr_n  = a_odd;
            din_n   = im_q;
            phase_n = 2'd2;
          end
          default: begin
            phase_n = 2'd0;
            if (k == 2'd3) begin
              state_n = S_WAIT;
              k_n     = 2'd0;
              wcnt_n  = 8'd0;
            end else begin
              k_n = k + 2'd1;
            end
          end
        endcase
      end

      // last wait cycle issues the first read so the bus idles WAIT_CYCLES
      S_WAIT: begin
        if (wcnt == WLAST) begin
          en_n    = 1'b1;
          addr_n  = a_even;
          state_n = S_READ;
          phase_n = 2'd1;
        end else begin
          wcnt_n = wcnt + 8'd1;
        end
      end

      S_READ: begin
        unique case (phase)
          2'd0: begin
            en_n    = 1'b1;
            addr_n  = a_even;
            phase_n = 2'd1;
          end
          2'd1: begin
            mre_n   = per_dout;
            en_n    = 1'b1;
            addr_n  = a_odd;
            phase_n = 2'd2;
          end
          default: begin
            mim_n   = per_dout;
            mv_n    = 1'b1;
            midx_n  = k;
            mlast_n = (k == 2'd3);
            phase_n = 2'd0;
            state_n = S_OUT;
          end
        endcase
      end

      S_OUT: begin
        if (m_ready) begin
          mv_n = 1'b0;
          if (k == 2'd3) begin
            state_n = S_LOAD;
            k_n     = 2'd0;
          end else begin
            k_n     = k + 2'd1;
            state_n = S_READ;
          end
        end
      end
    endcase

    if (flush) begin
      state_n = S_LOAD;
      k_n     = 2'd0;
      phase_n = 2'd0;
      en_n    = 1'b0;
      we_n    = 2'b00;
      mv_n    = 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bus_master.sv
// tb_fft_bus_master: directed scenarios against a model bus responder
// returning addr ^ 0x5A5A, plus a wrapped-address instance.
module tb_fft_bus_master;

  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_re = 16'd0;
  logic [15:0] s_im = 16'd0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_re, m_im;
  logic [1:0]  m_idx;
  logic        m_last;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        busy;

  logic        b_flush = 1'b0;
  logic        b_s_valid = 1'b0;
  logic        b_s_ready;
  logic [15:0] b_s_re = 16'd0;
  logic [15:0] b_s_im = 16'd0;
  logic        b_m_valid;
  logic        b_m_ready = 1'b0;
  logic [15:0] b_m_re, b_m_im;
  logic [1:0]  b_m_idx;
  logic        b_m_last;
  logic [13:0] b_addr;
  logic [15:0] b_din;
  logic        b_en;
  logic [1:0]  b_we;
  logic [15:0] b_dout;
  logic        b_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [13:0] la[512];
  logic [15:0] ld[512];
  logic [1:0]  lw[512];
  int          lc[512];
  int          ln = 0;
  int          bad_rdy = 0;

  logic [13:0] bla[64];
  logic [15:0] bld[64];
  logic [1:0]  blw[64];
  int          blc[64];
  int          bln = 0;

  logic [15:0] obs_re[4];
  logic [15:0] obs_im[4];
  logic [1:0]  obs_idx[4];
  logic        obs_last[4];
  int          obs_t[4];
  bit          send_ok;

  assign per_dout = {2'b00, per_addr} ^ 16'h5A5A;
  assign b_dout   = {2'b00, b_addr} ^ 16'h5A5A;

  fft_bus_master dut (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_re(s_re), .s_im(s_im),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_re(m_re), .m_im(m_im),
    .m_idx(m_idx), .m_last(m_last),
    .per_addr(per_addr), .per_din(per_din),
    .per_en(per_en), .per_we(per_we),
    .per_dout(per_dout), .busy(busy)
  );

  fft_bus_master #(
    .BASE_ADDR(14'h3FFC), .WAIT_CYCLES(1)
  ) dut_b (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .flush(b_flush),
    .s_valid(b_s_valid), .s_ready(b_s_ready),
    .s_re(b_s_re), .s_im(b_s_im),
    .m_valid(b_m_valid), .m_ready(b_m_ready),
    .m_re(b_m_re), .m_im(b_m_im),
    .m_idx(b_m_idx), .m_last(b_m_last),
    .per_addr(b_addr), .per_din(b_din),
    .per_en(b_en), .per_we(b_we),
    .per_dout(b_dout), .busy(b_busy)
  );

  always #5 mclk = ~mclk;

  always @(posedge mclk) cyc <= cyc + 1;

  always @(negedge mclk) begin
    if (per_en && ln < 512) begin
      la[ln] = per_addr;
      ld[ln] = per_din;
      lw[ln] = per_we;
      lc[ln] = cyc;
      ln = ln + 1;
    end
    if (s_ready && (per_en || m_valid))
      bad_rdy = bad_rdy + 1;
    if (b_en && bln < 64) begin
      bla[bln] = b_addr;
      bld[bln] = b_din;
      blw[bln] = b_we;
      blc[bln] = cyc;
      bln = bln + 1;
    end
  end

  task automatic nedge();
    @(negedge mclk);
    #1;
  endtask

  function automatic logic [15:0] wdat(input int i);
    if (i % 2 == 0) return 16'(i / 2 + 1);
    return 16'(-(i / 2 + 1));
  endfunction

  function automatic logic [15:0] rdat(input int a);
    return 16'(a) ^ 16'h5A5A;
  endfunction

  task automatic send(input logic [15:0] re, input logic [15:0] im,
                      output bit ok);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_re = re;
    s_im = im;
    while (s_ready !== 1'b1 && n < 100) begin
      nedge();
      n++;
    end
    ok = (s_ready === 1'b1);
    nedge();
    s_valid = 1'b0;
  endtask

  task automatic recv(output logic [15:0] re, output logic [15:0] im,
                      output logic [1:0] idx, output logic last,
                      output int t);
    int n;
    n = 0;
    m_ready = 1'b1;
    while (m_valid !== 1'b1 && n < 100) begin
      nedge();
      n++;
    end
    re = m_re;
    im = m_im;
    idx = m_idx;
    last = m_last;
    t = (m_valid === 1'b1) ? cyc : -1;
    nedge();
    m_ready = 1'b0;
  endtask

  task automatic run_frame();
    bit ok;
    send_ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(wdat(2 * k), wdat(2 * k + 1), ok);
      send_ok &= ok;
    end
    for (int k = 0; k < 4; k++)
      recv(obs_re[k], obs_im[k], obs_idx[k], obs_last[k], obs_t[k]);
  endtask

  task automatic test_reset();
    #1 puc_rst_n = 1'b0;
    nedge();
    checks++;
    if (per_en !== 1'b0 || per_we !== 2'b00 || per_addr !== 14'h0
        || per_din !== 16'h0)
      begin
        errors++;
        $display("FAIL reset_bus en=%b we=%b addr=%h din=%h required 0",
                 per_en, per_we, per_addr, per_din);
      end
    checks++;
    if (m_valid !== 1'b0 || m_re !== 16'h0 || m_im !== 16'h0
        || m_idx !== 2'd0 || m_last !== 1'b0 || busy !== 1'b0)
      begin
        errors++;
        $display("FAIL reset_stream mv=%b re=%h im=%h idx=%0d last=%b busy=%b required 0",
                 m_valid, m_re, m_im, m_idx, m_last, busy);
      end
    nedge();
    puc_rst_n = 1'b1;
    nedge();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready got %b required 1", s_ready);
    end
  endtask

  task automatic test_single_frame();
    int b;
    logic [13:0] ea;
    logic [1:0] ew;
    bit ok;
    b = ln;
    run_frame();
    checks++;
    if (!send_ok) begin
      errors++;
      $display("FAIL frame_accept got 0 required 1");
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (obs_re[k] !== rdat(16'h88 + 2 * k)
          || obs_im[k] !== rdat(16'h89 + 2 * k)
          || obs_idx[k] !== 2'(k) || obs_last[k] !== 1'(k == 3))
        begin
          errors++;
          $display("FAIL frame_result[%0d] re=%h im=%h idx=%0d last=%b required re=%h im=%h",
                   k, obs_re[k], obs_im[k], obs_idx[k], obs_last[k],
                   rdat(16'h88 + 2 * k), rdat(16'h89 + 2 * k));
        end
    end
    checks++;
    if (obs_t[1] - obs_t[0] != 4 || obs_t[3] - obs_t[2] != 4) begin
      errors++;
      $display("FAIL frame_spacing got %0d,%0d required 4",
               obs_t[1] - obs_t[0], obs_t[3] - obs_t[2]);
    end
    checks++;
    if (ln - b != 16) begin
      errors++;
      $display("FAIL frame_count got %0d required 16", ln - b);
    end
    for (int i = 0; i < 16; i++) begin
      ea = 14'(14'h88 + i % 8);
      ew = (i < 8) ? 2'b11 : 2'b00;
      checks++;
      if (la[b+i] !== ea || lw[b+i] !== ew
          || (i < 8 && ld[b+i] !== wdat(i)))
        begin
          errors++;
          $display("FAIL frame_bus[%0d] addr=%h we=%b din=%h required addr=%h we=%b din=%h",
                   i, la[b+i], lw[b+i], ld[b+i], ea, ew, wdat(i));
        end
    end
    checks++;
    if (lc[b+8] - lc[b+7] != 3) begin
      errors++;
      $display("FAIL frame_wait got %0d idle required 2",
               lc[b+8] - lc[b+7] - 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL frame_busy_end got %b required 0", busy);
    end
  endtask

  task automatic test_backpressure();
    int b, n, n0, t;
    bit ok, stable;
    logic [15:0] re, im, sre, sim;
    logic [1:0] idx, sidx;
    logic last;
    b = ln;
    for (int k = 0; k < 4; k++) send(wdat(2 * k), wdat(2 * k + 1), ok);
    recv(re, im, idx, last, t);
    n = 0;
    while (m_valid !== 1'b1 && n < 100) begin
      nedge();
      n++;
    end
    sre = m_re;
    sim = m_im;
    sidx = m_idx;
    n0 = ln;
    stable = 1'b1;
    repeat (10) begin
      nedge();
      if (m_valid !== 1'b1 || m_re !== sre || m_im !== sim
          || m_idx !== sidx)
        stable = 1'b0;
    end
    checks++;
    if (!stable || ln != n0) begin
      errors++;
      $display("FAIL bp_hold stable=%b bus_cycles=%0d required stable=1 bus_cycles=0",
               stable, ln - n0);
    end
    checks++;
    if (sre !== rdat(16'h8A) || sim !== rdat(16'h8B) || sidx !== 2'd1) begin
      errors++;
      $display("FAIL bp_value re=%h im=%h idx=%0d required re=%h im=%h idx=1",
               sre, sim, sidx, rdat(16'h8A), rdat(16'h8B));
    end
    for (int k = 1; k < 4; k++) begin
      recv(re, im, idx, last, t);
      checks++;
      if (re !== rdat(16'h88 + 2 * k) || idx !== 2'(k)) begin
        errors++;
        $display("FAIL bp_result[%0d] re=%h idx=%0d required re=%h idx=%0d",
                 k, re, idx, rdat(16'h88 + 2 * k), k);
      end
    end
    checks++;
    if (ln - b != 16 || la[b+10] !== 14'h8A) begin
      errors++;
      $display("FAIL bp_bus count=%0d addr10=%h required 16 08a",
               ln - b, la[b+10]);
    end
  endtask

  task automatic test_input_stall();
    int b, r0, nw, t;
    bit ok, ordered;
    logic [15:0] re, im;
    logic [1:0] idx;
    logic last;
    b = ln;
    r0 = bad_rdy;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, 3)) nedge();
      send(wdat(2 * k), wdat(2 * k + 1), ok);
    end
    for (int k = 0; k < 4; k++) recv(re, im, idx, last, t);
    nw = 0;
    ordered = 1'b1;
    for (int i = b; i < ln; i++) begin
      if (lw[i] == 2'b11) begin
        if (ld[i] !== wdat(nw) || la[i] !== 14'(14'h88 + nw))
          ordered = 1'b0;
        nw++;
      end
    end
    checks++;
    if (nw != 8 || !ordered) begin
      errors++;
      $display("FAIL stall_writes count=%0d ordered=%b required 8 1",
               nw, ordered);
    end
    checks++;
    if (bad_rdy != r0) begin
      errors++;
      $display("FAIL stall_s_ready got %0d bad cycles required 0",
               bad_rdy - r0);
    end
  endtask

  task automatic test_flush();
    int b, n, t;
    bit ok, good;
    logic [15:0] re, im;
    logic [1:0] idx;
    logic last;
    for (int k = 0; k < 4; k++) send(wdat(2 * k), wdat(2 * k + 1), ok);
    recv(re, im, idx, last, t);
    recv(re, im, idx, last, t);
    n = 0;
    while (!(per_en === 1'b1 && per_we === 2'b00 && per_addr === 14'h8C)
           && n < 100) begin
      nedge();
      n++;
    end
    flush = 1'b1;
    nedge();
    flush = 1'b0;
    checks++;
    if (n >= 100 || per_en !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_state en=%b mv=%b busy=%b required 0 0 0",
               per_en, m_valid, busy);
    end
    b = ln;
    run_frame();
    checks++;
    if (la[b] !== 14'h88 || ld[b] !== 16'h1 || lw[b] !== 2'b11) begin
      errors++;
      $display("FAIL flush_restart addr=%h din=%h required 088 0001",
               la[b], ld[b]);
    end
    good = send_ok && (ln - b == 16);
    for (int k = 0; k < 4; k++)
      if (obs_re[k] !== rdat(16'h88 + 2 * k) || obs_idx[k] !== 2'(k))
        good = 1'b0;
    checks++;
    if (!good) begin
      errors++;
      $display("FAIL flush_frame count=%0d re0=%h required 16 %h",
               ln - b, obs_re[0], rdat(16'h88));
    end
  endtask

  task automatic test_async_reset();
    int b;
    bit ok, good;
    send(wdat(0), wdat(1), ok);
    send(wdat(2), wdat(3), ok);
    nedge();
    checks++;
    if (per_en !== 1'b1 || per_addr !== 14'h8B || per_we !== 2'b11) begin
      errors++;
      $display("FAIL arst_pre en=%b addr=%h required 1 08b", per_en, per_addr);
    end
    #2 puc_rst_n = 1'b0;
    #1;
    checks++;
    if (per_en !== 1'b0 || per_we !== 2'b00 || per_addr !== 14'h0
        || per_din !== 16'h0 || m_valid !== 1'b0 || m_re !== 16'h0
        || m_im !== 16'h0 || m_idx !== 2'd0 || m_last !== 1'b0
        || busy !== 1'b0)
      begin
        errors++;
        $display("FAIL arst_outputs en=%b addr=%h din=%h mv=%b re=%h busy=%b required 0",
                 per_en, per_addr, per_din, m_valid, m_re, busy);
      end
    nedge();
    puc_rst_n = 1'b1;
    nedge();
    b = ln;
    run_frame();
    good = send_ok && (ln - b == 16);
    for (int i = 0; i < 8; i++)
      if (la[b+i] !== 14'(14'h88 + i) || ld[b+i] !== wdat(i))
        good = 1'b0;
    for (int k = 0; k < 4; k++)
      if (obs_im[k] !== rdat(16'h89 + 2 * k) || obs_last[k] !== 1'(k == 3))
        good = 1'b0;
    checks++;
    if (!good) begin
      errors++;
      $display("FAIL arst_frame count=%0d addr0=%h im3=%h required 16 088 %h",
               ln - b, la[b], obs_im[3], rdat(16'h8F));
    end
  endtask

  task automatic test_param_sweep();
    int bb, n;
    bit ok;
    logic [13:0] ea;
    logic [15:0] ed;
    logic [1:0] ew;
    ok = 1'b1;
    bb = bln;
    for (int k = 0; k < 4; k++) begin
      b_s_valid = 1'b1;
      b_s_re = 16'(k + 10);
      b_s_im = 16'(k + 20);
      n = 0;
      while (b_s_ready !== 1'b1 && n < 100) begin
        nedge();
        n++;
      end
      if (n >= 100) ok = 1'b0;
      nedge();
      b_s_valid = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sweep_accept got 0 required 1");
    end
    b_m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (b_m_valid !== 1'b1 && n < 100) begin
        nedge();
        n++;
      end
      ea = 14'h3FFC + 14'(2 * k);
      checks++;
      if (b_m_valid !== 1'b1 || b_m_re !== rdat(int'(ea))
          || b_m_im !== rdat(int'(14'(ea + 14'd1)))
          || b_m_idx !== 2'(k) || b_m_last !== 1'(k == 3))
        begin
          errors++;
          $display("FAIL sweep_result[%0d] re=%h im=%h idx=%0d required re=%h",
                   k, b_m_re, b_m_im, b_m_idx, rdat(int'(ea)));
        end
      nedge();
    end
    b_m_ready = 1'b0;
    checks++;
    if (bln - bb != 16) begin
      errors++;
      $display("FAIL sweep_count got %0d required 16", bln - bb);
    end
    for (int i = 0; i < 16; i++) begin
      ea = 14'h3FFC + 14'(i % 8);
      ew = (i < 8) ? 2'b11 : 2'b00;
      ed = (i % 2 == 0) ? 16'(i / 2 + 10) : 16'(i / 2 + 20);
      checks++;
      if (bla[bb+i] !== ea || blw[bb+i] !== ew
          || (i < 8 && bld[bb+i] !== ed))
        begin
          errors++;
          $display("FAIL sweep_bus[%0d] addr=%h we=%b din=%h required addr=%h we=%b din=%h",
                   i, bla[bb+i], blw[bb+i], bld[bb+i], ea, ew, ed);
        end
    end
    checks++;
    if (blc[bb+8] - blc[bb+7] != 2) begin
      errors++;
      $display("FAIL sweep_wait got %0d idle required 1",
               blc[bb+8] - blc[bb+7] - 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_input_stall();
    test_flush();
    test_async_reset();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
